// File: rtl/bcd_mod_counter.sv
// Modulo-N clock stage: counts carry/user edges with hold-to-repeat, preset load,
// one-cycle carry/borrow on wrap, and BCD digit outputs for the display path.
module bcd_mod_counter #(
  parameter int MODULUS       = 60,
  parameter int WIDTH         = 7,
  parameter int RESET_VALUE   = 0,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             carry_in,
  input  logic             inc_req,
  input  logic             dec_req,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             carry_out,
  output logic             borrow_out
);

  localparam int TIMER_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW        = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam int VW        = (WIDTH > 4) ? WIDTH : 4;
  localparam bit REPEAT_EN = (REPEAT_DELAY != 0);
  localparam logic [TW-1:0]    DELAY_LAST  = REPEAT_EN ? TW'(REPEAT_DELAY - 1) : '0;
  localparam logic [TW-1:0]    PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
  localparam logic [WIDTH-1:0] MAX_VAL     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL     = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH:0]   MOD_EXT     = (WIDTH + 1)'(MODULUS);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} repState_e;

  repState_e        state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             dirUp_q, dirUp_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             prevCarry_q, prevInc_q, prevDec_q;

  logic carryEdge, incEdge, decEdge;
  logic exitRepeat, repeatDue;
  logic stepUp, stepDown;
  logic [VW-1:0] valueExt;

  assign carryEdge = carry_in & ~prevCarry_q;
  assign incEdge   = inc_req & ~prevInc_q;
  assign decEdge   = dec_req & ~prevDec_q;

  // Repeat is abandoned once the held request drops or the opposite one is pressed.
  assign exitRepeat = dirUp_q ? (~inc_req | dec_req) : (~dec_req | inc_req);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      dirUp_q <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dirUp_q <= dirUp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dirUp_d = dirUp_q;
    if (load) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (REPEAT_EN && !carryEdge && (incEdge || decEdge)) begin
            state_d = DELAY;
            dirUp_d = incEdge;
            timer_d = '0;
          end
        end
        DELAY: begin
          if (exitRepeat) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (timer_q == DELAY_LAST) begin
            state_d = REPEAT;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        REPEAT: begin
          if (exitRepeat) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (timer_q == PERIOD_LAST) begin
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    repeatDue = 1'b0;
    if (!exitRepeat) begin
      if (state_q == DELAY && timer_q == DELAY_LAST) repeatDue = 1'b1;
      if (state_q == REPEAT && timer_q == PERIOD_LAST) repeatDue = 1'b1;
    end
  end

  // Only the highest-priority event acts; anything coinciding with it is dropped.
  always_comb begin
    stepUp   = 1'b0;
    stepDown = 1'b0;
    if (load) begin
      stepUp   = 1'b0;
    end else if (carryEdge || incEdge) begin
      stepUp   = 1'b1;
    end else if (decEdge) begin
      stepDown = 1'b1;
    end else if (repeatDue) begin
      stepUp   = dirUp_q;
      stepDown = ~dirUp_q;
    end
  end

  always_comb begin
    value_d  = value_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (load) begin
      value_d = ({1'b0, load_value} >= MOD_EXT) ? MAX_VAL : load_value;
    end else if (stepUp) begin
      if (value_q == MAX_VAL) begin
        value_d = '0;
        carry_d = 1'b1;
      end else begin
        value_d = value_q + WIDTH'(1);
      end
    end else if (stepDown) begin
      if (value_q == '0) begin
        value_d  = MAX_VAL;
        borrow_d = 1'b1;
      end else begin
        value_d = value_q - WIDTH'(1);
      end
    end
  end

  // Edge registers reset high so a request held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q     <= RST_VAL;
      carry_q     <= 1'b0;
      borrow_q    <= 1'b0;
      prevCarry_q <= 1'b1;
      prevInc_q   <= 1'b1;
      prevDec_q   <= 1'b1;
    end else begin
      value_q     <= value_d;
      carry_q     <= carry_d;
      borrow_q    <= borrow_d;
      prevCarry_q <= carry_in;
      prevInc_q   <= inc_req;
      prevDec_q   <= dec_req;
    end
  end

  assign valueExt   = VW'(value_q);
  assign tens       = 4'(valueExt / VW'(10));
  assign ones       = 4'(valueExt % VW'(10));
  assign value      = value_q;
  assign carry_out  = carry_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench for bcd_mod_counter: a 0..59 stage with short repeat timing and a
// 0..23 stage with auto-repeat disabled, driven by hand-computed directed vectors.
module tb_bcd_mod_counter;

  typedef struct {
    string name;
    bit    is24;
    int    v;
    int    t;
    int    o;
    bit    c;
    bit    b;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0, carry_in = 1'b0, inc_req = 1'b0, dec_req = 1'b0, load = 1'b0;
  logic [6:0] load_value = '0;
  logic [6:0] value;
  logic [3:0] tens, ones;
  logic       carry_out, borrow_out;

  logic       reset24 = 1'b0, inc24 = 1'b0, load24 = 1'b0;
  logic [6:0] lv24 = '0;
  logic [6:0] value24;
  logic [3:0] tens24, ones24;
  logic       carry24, borrow24;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  bcd_mod_counter #(
    .MODULUS(60), .WIDTH(7), .RESET_VALUE(58), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk), .reset(reset), .carry_in(carry_in), .inc_req(inc_req), .dec_req(dec_req),
    .load(load), .load_value(load_value), .value(value), .tens(tens), .ones(ones),
    .carry_out(carry_out), .borrow_out(borrow_out)
  );

  bcd_mod_counter #(
    .MODULUS(24), .WIDTH(7), .RESET_VALUE(7), .REPEAT_DELAY(0), .REPEAT_PERIOD(1)
  ) dut24 (
    .clk(clk), .reset(reset24), .carry_in(1'b0), .inc_req(inc24), .dec_req(1'b0),
    .load(load24), .load_value(lv24), .value(value24), .tens(tens24), .ones(ones24),
    .carry_out(carry24), .borrow_out(borrow24)
  );

  task automatic applyStimulus(input string name, input bit sel24, input bit rst, input bit cin,
                               input bit inc, input bit dec, input bit ld, input int lv,
                               input int ev, input int et, input int eo, input bit ec, input bit eb);
    exp_t e;
    @(negedge clk);
    if (!sel24) begin
      reset = rst; carry_in = cin; inc_req = inc; dec_req = dec; load = ld; load_value = 7'(lv);
    end else begin
      reset24 = rst; inc24 = inc; load24 = ld; lv24 = 7'(lv);
    end
    e.name = name; e.is24 = sel24; e.v = ev; e.t = et; e.o = eo; e.c = ec; e.b = eb;
    sb.push_back(e);
  endtask

  task automatic s60(input string name, input bit rst, input bit cin, input bit inc, input bit dec,
                     input bit ld, input int lv, input int ev, input int et, input int eo,
                     input bit ec, input bit eb);
    applyStimulus(name, 1'b0, rst, cin, inc, dec, ld, lv, ev, et, eo, ec, eb);
  endtask

  task automatic s24(input string name, input bit rst, input bit inc, input bit ld, input int lv,
                     input int ev, input int et, input int eo, input bit ec);
    applyStimulus(name, 1'b1, rst, 1'b0, inc, 1'b0, ld, lv, ev, et, eo, ec, 1'b0);
  endtask

  task automatic checkOutput(input exp_t e);
    int av, at, ao;
    bit ac, ab;
    av = e.is24 ? int'(value24) : int'(value);
    at = e.is24 ? int'(tens24)  : int'(tens);
    ao = e.is24 ? int'(ones24)  : int'(ones);
    ac = e.is24 ? carry24  : carry_out;
    ab = e.is24 ? borrow24 : borrow_out;
    compared++;
    if (av != e.v || at != e.t || ao != e.o || ac != e.c || ab != e.b) begin
      mismatched++;
      $display("[TB] FAIL %s: got v=%0d t=%0d o=%0d c=%0b b=%0b, want v=%0d t=%0d o=%0d c=%0b b=%0b",
               e.name, av, at, ao, ac, ab, e.v, e.t, e.o, e.c, e.b);
    end
  endtask

  // Each pushed expectation belongs to the clock edge right after it was driven.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    // Expected values in the repeat sequences are all single digits, so tens is 0.
    int rep1[20] = '{1,1,1,1,1,1,1,1,2,2,2,2,3,3,3,3,4,4,4,4};
    int blk[14]  = '{5,5,5,5,5,5,5,5,6,6,6,6,7,7};
    int rst9[10] = '{8,8,8,8,8,8,8,8,9,9};

    for (int i = 0; i < 3; i++) s60("reset_hold", 0, 0, 0, 0, 0, 0, 58, 5, 8, 0, 0);
    s60("reset_release",   1, 0, 0, 0, 0, 0, 58, 5, 8, 0, 0);
    s60("carry_to_59",     1, 1, 0, 0, 0, 0, 59, 5, 9, 0, 0);
    s60("carry_low",       1, 0, 0, 0, 0, 0, 59, 5, 9, 0, 0);
    s60("carry_wrap",      1, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    s60("carry_pulse_end", 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    s60("dec_wrap",        1, 0, 0, 1, 0, 0, 59, 5, 9, 0, 1);
    s60("borrow_end",      1, 0, 0, 0, 0, 0, 59, 5, 9, 0, 0);
    s60("dec_plain",       1, 0, 0, 1, 0, 0, 58, 5, 8, 0, 0);
    s60("dec_release",     1, 0, 0, 0, 0, 0, 58, 5, 8, 0, 0);
    s60("load_10",         1, 0, 0, 0, 1, 10, 10, 1, 0, 0, 0);
    s60("carry_beats_inc", 1, 1, 1, 0, 0, 0, 11, 1, 1, 0, 0);
    s60("dropped_inc_lost",1, 0, 1, 0, 0, 0, 11, 1, 1, 0, 0);
    s60("idle_11",         1, 0, 0, 0, 0, 0, 11, 1, 1, 0, 0);
    s60("load_59",         1, 0, 0, 0, 1, 59, 59, 5, 9, 0, 0);
    s60("load_beats_carry",1, 1, 0, 0, 1, 30, 30, 3, 0, 0, 0);
    s60("idle_30",         1, 0, 0, 0, 0, 0, 30, 3, 0, 0, 0);
    s60("load_clamp_99",   1, 0, 0, 0, 1, 99, 59, 5, 9, 0, 0);
    s60("load_clamp_60",   1, 0, 0, 0, 1, 60, 59, 5, 9, 0, 0);
    s60("load_0",          1, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0);
    s60("load_59b",        1, 0, 0, 0, 1, 59, 59, 5, 9, 0, 0);
    s60("inc_wrap",        1, 0, 1, 0, 0, 0,   0, 0, 0, 1, 0);
    s60("inc_release",     1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) s60("auto_repeat", 1, 0, 1, 0, 0, 0, rep1[i], 0, rep1[i], 0, 0);
    for (int i = 0; i < 6; i++)  s60("repeat_released", 1, 0, 0, 0, 0, 0, 4, 0, 4, 0, 0);

    for (int i = 0; i < 4; i++)  s60("inc_before_dec", 1, 0, 1, 0, 0, 0, 5, 0, 5, 0, 0);
    s60("dec_edge_while_inc", 1, 0, 1, 1, 0, 0, 4, 0, 4, 0, 0);
    for (int i = 0; i < 12; i++) s60("dec_stops_repeat", 1, 0, 1, 1, 0, 0, 4, 0, 4, 0, 0);
    s60("both_released", 1, 0, 0, 0, 0, 0, 4, 0, 4, 0, 0);

    for (int i = 0; i < 14; i++)
      s60("carry_blocks_repeat", 1, (i == 8), 1, 0, 0, 0, blk[i], 0, blk[i], 0, 0);
    s60("blk_released", 1, 0, 0, 0, 0, 0, 7, 0, 7, 0, 0);

    for (int i = 0; i < 10; i++) s60("repeat_pre_reset", 1, 0, 1, 0, 0, 0, rst9[i], 0, rst9[i], 0, 0);
    s60("reset_mid_repeat", 0, 0, 1, 0, 0, 0, 58, 5, 8, 0, 0);
    s60("reset_mid_repeat", 0, 0, 1, 0, 0, 0, 58, 5, 8, 0, 0);
    for (int i = 0; i < 12; i++) s60("held_through_reset", 1, 0, 1, 0, 0, 0, 58, 5, 8, 0, 0);
    s60("held_released",   1, 0, 0, 0, 0, 0, 58, 5, 8, 0, 0);
    s60("inc_after_reset", 1, 0, 1, 0, 0, 0, 59, 5, 9, 0, 0);
    s60("inc_after_rel",   1, 0, 0, 0, 0, 0, 59, 5, 9, 0, 0);
    s60("reset_beats_load",0, 0, 0, 0, 1, 10, 58, 5, 8, 0, 0);
    s60("reset_load_rel",  1, 0, 0, 0, 0, 0, 58, 5, 8, 0, 0);

    s24("m24_reset",      0, 0, 0, 0,   7, 0, 7, 0);
    s24("m24_release",    1, 0, 0, 0,   7, 0, 7, 0);
    s24("m24_clamp_99",   1, 0, 1, 99, 23, 2, 3, 0);
    s24("m24_clamp_24",   1, 0, 1, 24, 23, 2, 3, 0);
    s24("m24_load_23",    1, 0, 1, 23, 23, 2, 3, 0);
    s24("m24_wrap",       1, 1, 0, 0,   0, 0, 0, 1);
    for (int i = 0; i < 10; i++) s24("m24_no_repeat", 1, 1, 0, 0, 0, 0, 0, 0);
    s24("m24_release_inc",1, 0, 0, 0,   0, 0, 0, 0);
    s24("m24_inc",        1, 1, 0, 0,   1, 0, 1, 0);
    s24("m24_inc_rel",    1, 0, 0, 0,   1, 0, 1, 0);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
